// File: rtl/sci_host_master.sv
// SCI host master: free-running SCLK, one-byte TX holding register and framed
// TX/RX shifters (idle 1, start 0, 8 data bits LSB first, stop 1).
module sci_host_master #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sci_sclk,
  output logic       sci_txd,
  input  logic       sci_rxd,
  input  logic       sci_txr_n,
  output logic       sci_rxr_n,
  output logic       rx_err
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_e;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rxState_e;

  localparam logic [7:0] DivLast = 8'(CLKDIV - 1);

  logic [7:0] divCnt_q, divCnt_d;
  logic       sclk_q, sclk_d;
  logic [1:0] rxdSync_q, txrSync_q;
  logic       tick, riseEvt, fallEvt, rxdS, txrS, canStart;

  txState_e   txState_q, txState_d;
  logic [7:0] holdData_q, holdData_d;
  logic       holdFull_q, holdFull_d;
  logic [7:0] txShift_q, txShift_d;
  logic [2:0] txBitCnt_q, txBitCnt_d;
  logic       txd_q, txd_d;

  rxState_e   rxState_q, rxState_d;
  logic [7:0] rxShift_q, rxShift_d;
  logic [2:0] rxBitCnt_q, rxBitCnt_d;
  logic [7:0] outData_q, outData_d;
  logic       outValid_q, outValid_d;
  logic       rxErr_q, rxErr_d;
  logic       rxrN_q, rxrN_d;

  assign tick     = (divCnt_q == DivLast);
  assign riseEvt  = tick & ~sclk_q;
  assign fallEvt  = tick & sclk_q;
  assign rxdS     = rxdSync_q[1];
  assign txrS     = txrSync_q[1];
  assign canStart = holdFull_q & ~txrS;
  assign divCnt_d = tick ? 8'd0 : divCnt_q + 8'd1;
  assign sclk_d   = tick ? ~sclk_q : sclk_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState_q <= TX_IDLE;
      rxState_q <= RX_IDLE;
    end else begin
      txState_q <= txState_d;
      rxState_q <= rxState_d;
    end
  end

  // Synchronizers idle high so a released reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt_q   <= '0;
      sclk_q     <= 1'b0;
      rxdSync_q  <= 2'b11;
      txrSync_q  <= 2'b11;
      holdData_q <= '0;
      holdFull_q <= 1'b0;
      txShift_q  <= '0;
      txBitCnt_q <= '0;
      txd_q      <= 1'b1;
      rxShift_q  <= '0;
      rxBitCnt_q <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      rxErr_q    <= 1'b0;
      rxrN_q     <= 1'b1;
    end else begin
      divCnt_q   <= divCnt_d;
      sclk_q     <= sclk_d;
      rxdSync_q  <= {rxdSync_q[0], sci_rxd};
      txrSync_q  <= {txrSync_q[0], sci_txr_n};
      holdData_q <= holdData_d;
      holdFull_q <= holdFull_d;
      txShift_q  <= txShift_d;
      txBitCnt_q <= txBitCnt_d;
      txd_q      <= txd_d;
      rxShift_q  <= rxShift_d;
      rxBitCnt_q <= rxBitCnt_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      rxErr_q    <= rxErr_d;
      rxrN_q     <= rxrN_d;
    end
  end

  always_comb begin
    txState_d = txState_q;
    if (fallEvt) begin
      unique case (txState_q)
        TX_IDLE:  if (canStart) txState_d = TX_START;
        TX_START: txState_d = TX_DATA;
        TX_DATA:  if (txBitCnt_q == 3'd7) txState_d = TX_STOP;
        TX_STOP:  txState_d = canStart ? TX_START : TX_IDLE;
        default:  txState_d = TX_IDLE;
      endcase
    end
  end

  // txd is registered; each state's value is launched on the fall that enters it.
  always_comb begin
    holdData_d = holdData_q;
    holdFull_d = holdFull_q;
    txShift_d  = txShift_q;
    txBitCnt_d = txBitCnt_q;
    txd_d      = txd_q;
    if (in_valid && !holdFull_q) begin
      holdData_d = in_data;
      holdFull_d = 1'b1;
    end
    if (fallEvt) begin
      unique case (txState_q)
        TX_IDLE, TX_STOP: begin
          if (canStart) begin
            txShift_d  = holdData_q;
            holdFull_d = 1'b0;
            txd_d      = 1'b0;
          end else begin
            txd_d = 1'b1;
          end
        end
        TX_START: begin
          txd_d      = txShift_q[0];
          txShift_d  = {1'b0, txShift_q[7:1]};
          txBitCnt_d = 3'd0;
        end
        TX_DATA: begin
          if (txBitCnt_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            txd_d      = txShift_q[0];
            txShift_d  = {1'b0, txShift_q[7:1]};
            txBitCnt_d = txBitCnt_q + 3'd1;
          end
        end
        default: txd_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    rxState_d = rxState_q;
    if (riseEvt) begin
      unique case (rxState_q)
        RX_IDLE: if (!rxdS) rxState_d = RX_DATA;
        RX_DATA: if (rxBitCnt_q == 3'd7) rxState_d = RX_STOP;
        RX_STOP: rxState_d = RX_IDLE;
        default: rxState_d = RX_IDLE;
      endcase
    end
  end

  // A byte is only loaded into an empty buffer, so load and handshake never collide.
  always_comb begin
    rxShift_d  = rxShift_q;
    rxBitCnt_d = rxBitCnt_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    rxErr_d    = 1'b0;
    if (outValid_q && out_ready) outValid_d = 1'b0;
    if (riseEvt) begin
      unique case (rxState_q)
        RX_IDLE: rxBitCnt_d = 3'd0;
        RX_DATA: begin
          rxShift_d  = {rxdS, rxShift_q[7:1]};
          rxBitCnt_d = rxBitCnt_q + 3'd1;
        end
        RX_STOP: begin
          if (!rxdS || outValid_q) begin
            rxErr_d = 1'b1;
          end else begin
            outData_d  = rxShift_q;
            outValid_d = 1'b1;
          end
        end
        default: rxBitCnt_d = 3'd0;
      endcase
    end
    rxrN_d = outValid_d;
  end

  assign in_ready  = ~holdFull_q;
  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign sci_sclk  = sclk_q;
  assign sci_txd   = txd_q;
  assign sci_rxr_n = rxrN_q;
  assign rx_err    = rxErr_q;

endmodule
